imm_narrow_unit: RTL and testbench

//   Inverse of the sign-extension path. Narrows IN_W-bit words to OUT_W-bit immediates,
//   e.g. 32-bit branch/offset values packed into the 16-bit instruction immediate field.

---
 rtl/imm_narrow_pkg.sv | 13 +
 rtl/narrow_fifo2.sv | 50 +++++
 rtl/imm_narrow_unit.sv | 87 ++++++++
 tb/tb_imm_narrow_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/imm_narrow_pkg.sv
// Shared widths and the output entry record for the immediate narrowing unit.
package imm_narrow_pkg;
    localparam int IN_W_DEF  = 32;
    localparam int OUT_W_DEF = 16;
    localparam int CNT_W_DEF = 16;

    typedef struct packed {
        logic [OUT_W_DEF-1:0] data;
        logic                 ovf;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/narrow_fifo2.sv
// Two-entry FIFO of packed entry records; reports occupancy and exposes the head entry.
module narrow_fifo2
    import imm_narrow_pkg::*;
#(
    parameter int W = ENTRY_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        wr_d    = push_i ? ~wr_q : wr_q;
        rd_d    = pop_i  ? ~rd_q : rd_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/imm_narrow_unit.sv
// Narrows IN_W-bit words to OUT_W-bit immediates with overflow flag and counter.
// Define SATURATE_EN to clamp overflowing words instead of truncating them.
module imm_narrow_unit
    import imm_narrow_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clear
);
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             ovf;
    } ent_t;

    logic             fit;
    logic [OUT_W-1:0] narrowed;
    ent_t             push_ent, head_ent;
    logic [1:0]       count;
    logic             accept, pop;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SATURATE_EN
    function automatic logic [OUT_W-1:0] sat_narrow(input logic [IN_W-1:0] d,
                                                    input logic uns, input logic ok);
        if (ok)  return d[OUT_W-1:0];
        if (uns) return '1;
        return d[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    endfunction
`endif

    always_comb begin
        if (in_unsigned) fit = (in_data[IN_W-1:OUT_W] == '0);
        else             fit = (in_data[IN_W-1:OUT_W-1] == '0) || (in_data[IN_W-1:OUT_W-1] == '1);
`ifdef SATURATE_EN
        narrowed = sat_narrow(in_data, in_unsigned, fit);
`else
        narrowed = in_data[OUT_W-1:0];
`endif
        push_ent.data = narrowed;
        push_ent.ovf  = ~fit;
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    narrow_fifo2 #(.W($bits(ent_t))) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .wdata_i (push_ent),
        .pop_i   (pop),
        .head_o  (head_ent),
        .count_o (count)
    );

    // Stale FIFO storage is masked so the outputs read zero whenever nothing is buffered.
    assign out_data = out_valid ? head_ent.data : '0;
    assign out_ovf  = out_valid & head_ent.ovf;

    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clear)                              cnt_d = '0;
        else if (accept && !fit && (cnt_q != '1))   cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign ovf_count = cnt_q;
endmodule

// File: tb/tb_imm_narrow_unit.sv
// Directed self-checking bench for imm_narrow_unit; honours SATURATE_EN for expectations.
module tb_imm_narrow_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic [15:0] ovf_count;
    logic        ovf_clear;

    int errors = 0;
    int checks = 0;

`ifdef SATURATE_EN
    localparam logic [15:0] EXP_S_POS_OVF = 16'h7FFF;
    localparam logic [15:0] EXP_S_NEG_OVF = 16'h8000;
    localparam logic [15:0] EXP_U_OVF     = 16'hFFFF;
`else
    localparam logic [15:0] EXP_S_POS_OVF = 16'hAFDE;
    localparam logic [15:0] EXP_S_NEG_OVF = 16'h7FFF;
    localparam logic [15:0] EXP_U_OVF     = 16'h0000;
`endif

    imm_narrow_unit dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_unsigned (in_unsigned),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .ovf_count   (ovf_count),
        .ovf_clear   (ovf_clear)
    );

    always #5 clk = ~clk;

    // Presents one word for a single cycle; outputs are then sampled on the following negedge.
    task automatic send(input logic [31:0] d, input logic uns);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_unsigned = uns;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_unsigned = 1'b0;
        out_ready = 1'b1; ovf_clear = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
        checks++; if (ovf_count !== 16'h0) begin errors++; $display("FAIL reset_ovf_count: got %h expected 0000", ovf_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_signed();
        out_ready = 1'b1;
        send(32'h0000_01DD, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h01DD || out_ovf !== 1'b0) begin
            errors++; $display("FAIL signed_fit: got v=%b d=%h o=%b expected v=1 d=01dd o=0", out_valid, out_data, out_ovf); end
        send(32'hFFFF_AFDE, 1'b0);
        checks++; if (out_data !== 16'hAFDE || out_ovf !== 1'b0) begin
            errors++; $display("FAIL signed_neg_fit: got d=%h o=%b expected d=afde o=0", out_data, out_ovf); end
        send(32'h0000_AFDE, 1'b0);
        checks++; if (out_data !== EXP_S_POS_OVF || out_ovf !== 1'b1) begin
            errors++; $display("FAIL signed_pos_ovf: got d=%h o=%b expected d=%h o=1", out_data, out_ovf, EXP_S_POS_OVF); end
        checks++; if (ovf_count !== 16'd1) begin errors++; $display("FAIL signed_ovf_count: got %h expected 0001", ovf_count); end
        send(32'hFFFF_8000, 1'b0);
        checks++; if (out_data !== 16'h8000 || out_ovf !== 1'b0) begin
            errors++; $display("FAIL signed_min_fit: got d=%h o=%b expected d=8000 o=0", out_data, out_ovf); end
        send(32'hFFFF_7FFF, 1'b0);
        checks++; if (out_data !== EXP_S_NEG_OVF || out_ovf !== 1'b1) begin
            errors++; $display("FAIL signed_neg_ovf: got d=%h o=%b expected d=%h o=1", out_data, out_ovf, EXP_S_NEG_OVF); end
    endtask

    task automatic test_unsigned();
        send(32'h0000_FFFF, 1'b1);
        checks++; if (out_data !== 16'hFFFF || out_ovf !== 1'b0) begin
            errors++; $display("FAIL unsigned_fit: got d=%h o=%b expected d=ffff o=0", out_data, out_ovf); end
        send(32'h0001_0000, 1'b1);
        checks++; if (out_data !== EXP_U_OVF || out_ovf !== 1'b1) begin
            errors++; $display("FAIL unsigned_ovf: got d=%h o=%b expected d=%h o=1", out_data, out_ovf, EXP_U_OVF); end
        checks++; if (ovf_count !== 16'd3) begin errors++; $display("FAIL unsigned_ovf_count: got %h expected 0003", ovf_count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_unsigned = 1'b1; in_data = 32'h0000_1111;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h1111 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_first: got v=%b d=%h r=%b expected v=1 d=1111 r=1", out_valid, out_data, in_ready); end
        in_data = 32'h0000_2222;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_data !== 16'h1111) begin
            errors++; $display("FAIL bp_full: got r=%b d=%h expected r=0 d=1111", in_ready, out_data); end
        in_data = 32'h0000_3333;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_data !== 16'h1111 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got r=%b d=%h v=%b expected r=0 d=1111 v=1", in_ready, out_data, out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_data !== 16'h2222 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_second: got d=%h r=%b expected d=2222 r=1", out_data, in_ready); end
        @(negedge clk);
        checks++; if (out_data !== 16'h3333 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_third: got d=%h v=%b expected d=3333 v=1", out_data, out_valid); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_counter();
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        checks++; if (ovf_count !== 16'h0) begin errors++; $display("FAIL cnt_clear: got %h expected 0000", ovf_count); end
        out_ready = 1'b1; in_valid = 1'b1; in_unsigned = 1'b1; in_data = 32'h0001_0000;
        repeat (65534) @(negedge clk);
        checks++; if (ovf_count !== 16'hFFFE) begin errors++; $display("FAIL cnt_fffe: got %h expected fffe", ovf_count); end
        @(negedge clk);
        checks++; if (ovf_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_ffff: got %h expected ffff", ovf_count); end
        repeat (4465) @(negedge clk);
        checks++; if (ovf_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat_hold: got %h expected ffff", ovf_count); end
        ovf_clear = 1'b1;
        @(negedge clk);
        checks++; if (ovf_count !== 16'h0) begin errors++; $display("FAIL cnt_clear_priority: got %h expected 0000", ovf_count); end
        ovf_clear = 1'b0;
        @(negedge clk);
        checks++; if (ovf_count !== 16'h1) begin errors++; $display("FAIL cnt_resume: got %h expected 0001", ovf_count); end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0; in_valid = 1'b1; in_unsigned = 1'b0; in_data = 32'h0000_0042;
        @(negedge clk);
        in_data = 32'h0001_0000;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0042) begin
            errors++; $display("FAIL mid_full: got r=%b v=%b d=%h expected r=0 v=1 d=0042", in_ready, out_valid, out_data); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_count !== 16'h0 || out_data !== 16'h0) begin
            errors++; $display("FAIL mid_reset: got v=%b r=%b c=%h d=%h expected v=0 r=1 c=0000 d=0000",
                               out_valid, in_ready, ovf_count, out_data); end
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 1'b0);
        checks++; if (out_data !== 16'hFFFF || out_ovf !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL post_reset: got d=%h o=%b v=%b expected d=ffff o=0 v=1", out_data, out_ovf, out_valid); end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_backpressure();
        test_counter();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
